// File: rtl/multi_channel_artau.sv
// ----------------------------------------------------------------------------
// multi_channel_artau
// Multi-channel radar ranging and threat unit. One transmitter is shared by
// NUM_CH antenna channels under round-robin arbitration. Each scan measures the
// echo time-of-flight, converts it to metres and updates that channel's
// distance, target-present and closing-threat status.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module multi_channel_artau #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 16,
  parameter int DIST_W       = 32,
  parameter int PULSE_CYCLES = 50,
  parameter int TIMEOUT      = 2000,
  parameter int M_PER_CYCLE  = 150,
  parameter int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [NUM_CH-1:0]        scan_req,
  input  logic [NUM_CH-1:0]        radar_echo,
  input  logic [DIST_W-1:0]        max_safe_distance,
  output logic [NUM_CH-1:0]        radar_pulse_trigger,
  output logic                     busy,
  output logic [CH_W-1:0]          active_ch,
  output logic                     meas_valid,
  output logic [CH_W-1:0]          meas_ch,
  output logic [DIST_W-1:0]        meas_distance,
  output logic [NUM_CH*DIST_W-1:0] distance_flat,
  output logic [NUM_CH-1:0]        target_present,
  output logic [NUM_CH-1:0]        threat_detected,
  output logic                     any_threat,
  output logic [1:0]               ARTAU_state
);

  // Full-width product so the saturation check sees every overflow bit.
  localparam int PW = CNT_W + 32;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EMIT   = 2'd1,
    S_LISTEN = 2'd2,
    S_ASSESS = 2'd3
  } state_t;

  state_t              state_q;
  logic [CH_W-1:0]     active_ch_q;
  logic [CH_W-1:0]     last_grant_q;
  logic [31:0]         pcnt_q;
  logic [CNT_W-1:0]    lcnt_q;
  logic [CNT_W-1:0]    tof_q;
  logic                hit_q;
  logic [DIST_W-1:0]   dist_q      [NUM_CH];
  logic [DIST_W-1:0]   prev_dist_q [NUM_CH];
  logic [NUM_CH-1:0]   prev_valid_q;
  logic [NUM_CH-1:0]   target_q;
  logic [NUM_CH-1:0]   threat_q;
  logic                meas_valid_q;
  logic [CH_W-1:0]     meas_ch_q;
  logic [DIST_W-1:0]   meas_dist_q;

  logic [CH_W-1:0]     grant_d;
  logic                grant_vld_d;
  logic [PW-1:0]       prod_d;
  logic [DIST_W-1:0]   dist_d;
  logic [DIST_W-1:0]   assess_dist_d;
  logic                closing_d;

  // Round-robin pick: first requesting channel after last_grant, wrapping.
  always_comb begin
    logic [CH_W:0] sum;
    grant_d     = last_grant_q;
    grant_vld_d = 1'b0;
    sum         = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      sum = {1'b0, last_grant_q} + (CH_W+1)'(i);
      if (sum >= (CH_W+1)'(NUM_CH)) begin
        sum = sum - (CH_W+1)'(NUM_CH);
      end
      if (!grant_vld_d && scan_req[sum[CH_W-1:0]]) begin
        grant_d     = sum[CH_W-1:0];
        grant_vld_d = 1'b1;
      end
    end
  end

  assign prod_d = PW'(tof_q) * PW'(M_PER_CYCLE);

  // Clamp distances that do not fit the output lane to all-ones.
  generate
    if (PW > DIST_W) begin : g_sat
      assign dist_d = (|prod_d[PW-1:DIST_W]) ? {DIST_W{1'b1}} : prod_d[DIST_W-1:0];
    end else begin : g_nosat
      assign dist_d = DIST_W'(prod_d);
    end
  endgenerate

  assign assess_dist_d = hit_q ? dist_d : {DIST_W{1'b1}};
  // Closing means strictly nearer than the last hit and inside the safe range.
  assign closing_d = prev_valid_q[active_ch_q] &&
                     (dist_d < prev_dist_q[active_ch_q]) &&
                     (dist_d < max_safe_distance);

  // Scan sequencer: arbitrate, emit, listen, then publish the measurement.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= S_IDLE;
      active_ch_q  <= '0;
      last_grant_q <= CH_W'(NUM_CH - 1);
      pcnt_q       <= '0;
      lcnt_q       <= '0;
      tof_q        <= '0;
      hit_q        <= 1'b0;
      prev_valid_q <= '0;
      target_q     <= '0;
      threat_q     <= '0;
      meas_valid_q <= 1'b0;
      meas_ch_q    <= '0;
      meas_dist_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        dist_q[i]      <= {DIST_W{1'b1}};
        prev_dist_q[i] <= '0;
      end
    end else begin
      meas_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_vld_d) begin
            active_ch_q  <= grant_d;
            last_grant_q <= grant_d;
            pcnt_q       <= '0;
            state_q      <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (pcnt_q == 32'(PULSE_CYCLES - 1)) begin
            lcnt_q  <= CNT_W'(1);
            state_q <= S_LISTEN;
          end else begin
            pcnt_q <= pcnt_q + 32'd1;
          end
        end
        S_LISTEN: begin
          if (radar_echo[active_ch_q]) begin
            tof_q   <= lcnt_q;
            hit_q   <= 1'b1;
            state_q <= S_ASSESS;
          end else if (lcnt_q == CNT_W'(TIMEOUT)) begin
            tof_q   <= '0;
            hit_q   <= 1'b0;
            state_q <= S_ASSESS;
          end else begin
            lcnt_q <= lcnt_q + CNT_W'(1);
          end
        end
        S_ASSESS: begin
          dist_q[active_ch_q]       <= assess_dist_d;
          target_q[active_ch_q]     <= hit_q;
          threat_q[active_ch_q]     <= hit_q && closing_d;
          prev_valid_q[active_ch_q] <= hit_q;
          if (hit_q) begin
            prev_dist_q[active_ch_q] <= dist_d;
          end
          meas_valid_q <= 1'b1;
          meas_ch_q    <= active_ch_q;
          meas_dist_q  <= assess_dist_d;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_flat
      assign distance_flat[gi*DIST_W +: DIST_W] = dist_q[gi];
    end
  endgenerate

  assign radar_pulse_trigger = (state_q == S_EMIT) ? (NUM_CH'(1) << active_ch_q) : '0;
  assign busy                = (state_q != S_IDLE);
  assign active_ch           = active_ch_q;
  assign meas_valid          = meas_valid_q;
  assign meas_ch             = meas_ch_q;
  assign meas_distance       = meas_dist_q;
  assign target_present      = target_q;
  assign threat_detected     = threat_q;
  assign any_threat          = |threat_q;
  assign ARTAU_state         = state_q;

endmodule

`default_nettype wire

// File: tb/tb_multi_channel_artau.sv
// ----------------------------------------------------------------------------
// tb_multi_channel_artau
// Directed bench for multi_channel_artau with NUM_CH=4, PULSE_CYCLES=2,
// TIMEOUT=8, M_PER_CYCLE=150. Expected values are hand-computed.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_multi_channel_artau;

  localparam int NUM_CH = 4;
  localparam int DIST_W = 32;
  localparam int CH_W   = 2;

  logic                     CLK;
  logic                     RST_N;
  logic [NUM_CH-1:0]        scan_req;
  logic [NUM_CH-1:0]        radar_echo;
  logic [DIST_W-1:0]        max_safe_distance;
  logic [NUM_CH-1:0]        radar_pulse_trigger;
  logic                     busy;
  logic [CH_W-1:0]          active_ch;
  logic                     meas_valid;
  logic [CH_W-1:0]          meas_ch;
  logic [DIST_W-1:0]        meas_distance;
  logic [NUM_CH*DIST_W-1:0] distance_flat;
  logic [NUM_CH-1:0]        target_present;
  logic [NUM_CH-1:0]        threat_detected;
  logic                     any_threat;
  logic [1:0]               ARTAU_state;

  int n_tests;
  int n_fail;

  multi_channel_artau #(
    .NUM_CH       (NUM_CH),
    .CNT_W        (16),
    .DIST_W       (DIST_W),
    .PULSE_CYCLES (2),
    .TIMEOUT      (8),
    .M_PER_CYCLE  (150)
  ) u_dut (
    .CLK                 (CLK),
    .RST_N               (RST_N),
    .scan_req            (scan_req),
    .radar_echo          (radar_echo),
    .max_safe_distance   (max_safe_distance),
    .radar_pulse_trigger (radar_pulse_trigger),
    .busy                (busy),
    .active_ch           (active_ch),
    .meas_valid          (meas_valid),
    .meas_ch             (meas_ch),
    .meas_distance       (meas_distance),
    .distance_flat       (distance_flat),
    .target_present      (target_present),
    .threat_detected     (threat_detected),
    .any_threat          (any_threat),
    .ARTAU_state         (ARTAU_state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one scan from the current negedge until meas_valid is seen.
  task automatic do_scan(input logic [3:0] req, input bit hold, input int echo_ch,
                         input int k, input bit stray2, input int exp_ch,
                         input logic [31:0] exp_dist, input bit exp_tp,
                         input bit exp_thr, input bit exp_any);
    int  l_cnt;
    int  trig;
    int  cyc;
    bit  done;
    bit  first_emit;
    l_cnt      = 0;
    trig       = 0;
    cyc        = 0;
    done       = 1'b0;
    first_emit = 1'b1;
    scan_req   = req;
    radar_echo = '0;
    while (!done && cyc < 200) begin
      @(negedge CLK);
      cyc++;
      if (ARTAU_state == 2'd1) begin
        trig++;
        chk("trigger", 128'(radar_pulse_trigger), 128'(4'b0001 << exp_ch));
        if (first_emit) begin
          chk("grant", 128'(active_ch), 128'(exp_ch));
          first_emit = 1'b0;
        end
      end
      if (busy && !hold) scan_req = '0;
      if (ARTAU_state == 2'd2) begin
        l_cnt++;
        radar_echo = '0;
        if (l_cnt == k && echo_ch >= 0) radar_echo[echo_ch] = 1'b1;
        if (stray2) radar_echo[2] = 1'b1;
      end else begin
        radar_echo = '0;
      end
      if (meas_valid) done = 1'b1;
    end
    chk("scan_done", 128'(done), 128'(1));
    chk("pulse_len", 128'(trig), 128'(2));
    chk("scan_len", 128'(cyc), 128'(exp_tp ? k + 4 : 12));
    chk("meas_ch", 128'(meas_ch), 128'(exp_ch));
    chk("meas_dist", 128'(meas_distance), 128'(exp_dist));
    chk("lane", 128'(distance_flat[exp_ch*DIST_W +: DIST_W]), 128'(exp_dist));
    chk("target", 128'(target_present[exp_ch]), 128'(exp_tp));
    chk("threat", 128'(threat_detected[exp_ch]), 128'(exp_thr));
    chk("any_threat", 128'(any_threat), 128'(exp_any));
  endtask

  initial begin
    int w;
    n_tests           = 0;
    n_fail            = 0;
    RST_N             = 1'b0;
    scan_req          = '0;
    radar_echo        = '0;
    max_safe_distance = 32'd1000;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    chk("rst_dist", 128'(distance_flat), {128{1'b1}});
    chk("rst_state", 128'(ARTAU_state), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_flags", 128'({target_present, threat_detected, any_threat, meas_valid}), 128'(0));
    chk("rst_trig", 128'(radar_pulse_trigger), 128'(0));

    // First measurement on channel 0: no previous value, so no threat.
    do_scan(4'b0001, 1'b0, 0, 4, 1'b0, 0, 32'd600, 1'b1, 1'b0, 1'b0);
    // Closer and inside the safe range: threat.
    do_scan(4'b0001, 1'b0, 0, 3, 1'b0, 0, 32'd450, 1'b1, 1'b1, 1'b1);
    // Same distance is not closing.
    do_scan(4'b0001, 1'b0, 0, 3, 1'b0, 0, 32'd450, 1'b1, 1'b0, 1'b0);

    // Held 1011 after last grant 0: order 1, 3, 0. Channel 1 misses with a
    // stray echo on channel 2 during its listen window.
    do_scan(4'b1011, 1'b1, -1, 0, 1'b1, 1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    do_scan(4'b1011, 1'b1, 3, 2, 1'b0, 3, 32'd300, 1'b1, 1'b0, 1'b0);
    do_scan(4'b1011, 1'b1, 0, 5, 1'b0, 0, 32'd750, 1'b1, 1'b0, 1'b0);
    scan_req = '0;
    chk("lanes", 128'(distance_flat), 128'h0000012C_FFFFFFFF_FFFFFFFF_000002EE);

    // Channel 3 closes from 300 to 150.
    do_scan(4'b1000, 1'b0, 3, 1, 1'b0, 3, 32'd150, 1'b1, 1'b1, 1'b1);
    // Channel 0 closes 750 -> 600 but 600 is not below a 500 threshold.
    max_safe_distance = 32'd500;
    do_scan(4'b0001, 1'b0, 0, 4, 1'b0, 0, 32'd600, 1'b1, 1'b0, 1'b1);
    max_safe_distance = 32'd1000;

    // Asynchronous reset in the middle of a listen window.
    scan_req = 4'b0100;
    w = 0;
    while (ARTAU_state != 2'd2 && w < 50) begin
      @(negedge CLK);
      w++;
    end
    chk("reach_listen", 128'(ARTAU_state), 128'(2));
    scan_req = '0;
    repeat (2) @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    chk("mid_rst_state", 128'(ARTAU_state), 128'(0));
    chk("mid_rst_dist", 128'(distance_flat), {128{1'b1}});
    chk("mid_rst_flags", 128'({target_present, threat_detected, any_threat, busy, radar_pulse_trigger}), 128'(0));
    @(negedge CLK);
    RST_N = 1'b1;
    // All channels requesting: channel 0 is served first; no prior hit.
    do_scan(4'b1111, 1'b0, 0, 2, 1'b0, 0, 32'd300, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
